// File: rtl/axi_seq_pkg.sv
// Shared types and defaults for the sequential AXI traffic master.
// Holds the FSM state enum, default sizing and the data-pattern function.
package axi_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREQ,
    S_WDATA,
    S_RREQ,
    S_RDATA,
    S_DONE
  } state_e;

  localparam int DEF_WR_LEN       = 18;
  localparam int DEF_DATA_INIT    = 0;
  localparam int DEF_DATA_STEP    = 2;
  localparam int DEF_NUM_RD       = 3;
  localparam int DEF_RD_SIZE_INIT = 3;
  localparam int DEF_RD_SIZE_STEP = 3;

  // Pattern word at a given word address; callers keep the low bits.
  function automatic logic [63:0] expected_data(
    input logic [63:0] addr,
    input logic [63:0] init,
    input logic [63:0] step
  );
    return init + addr * step;
  endfunction

endpackage

// File: rtl/axi_seq_master_checker.sv
// Read-data checker: compares each accepted R word with the pattern.
// Ports: CLK/RESET, clear_i, fire_i, check_en_i, addr_i, r_data_i -> error_o, err_count_o.
module axi_rd_checker
  import axi_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DATA_INIT = DEF_DATA_INIT,
  parameter int DATA_STEP = DEF_DATA_STEP
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clear_i,
  input  logic              fire_i,
  input  logic              check_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] r_data_i,
  output logic              error_o,
  output logic [7:0]        err_count_o
);

  logic [63:0] exp_full;
  logic        mismatch;
  logic        error_q;
  logic [7:0]  err_q;

  always_comb begin
    exp_full = expected_data(64'(addr_i), 64'(DATA_INIT),
                             64'(DATA_STEP));
    mismatch = fire_i && check_en_i &&
               (r_data_i != exp_full[DATA_W-1:0]);
  end

  always_ff @(posedge CLK) begin
    if (RESET || clear_i) begin
      error_q <= 1'b0;
      err_q   <= 8'd0;
    end else if (mismatch) begin
      error_q <= 1'b1;
      if (err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign error_o     = error_q;
  assign err_count_o = err_q;

endmodule

// File: rtl/axi_seq_master.sv
// Sequential traffic master: one write burst of a ramp, chunked readback, check.
// Ports: CLK/RESET, start, busy/done/error/err_count, WReq/W/RReq/R channels.
module axi_seq_master
  import axi_seq_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int WR_LEN       = DEF_WR_LEN,
  parameter int DATA_INIT    = DEF_DATA_INIT,
  parameter int DATA_STEP    = DEF_DATA_STEP,
  parameter int NUM_RD       = DEF_NUM_RD,
  parameter int RD_SIZE_INIT = DEF_RD_SIZE_INIT,
  parameter int RD_SIZE_STEP = DEF_RD_SIZE_STEP
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] WReq_addr,
  output logic [ADDR_W-1:0] WReq_size,
  output logic              WReq_valid,
  input  logic              WReq_ready,
  output logic [DATA_W-1:0] W_data,
  output logic              W_valid,
  input  logic              W_ready,
  output logic [ADDR_W-1:0] RReq_addr,
  output logic [ADDR_W-1:0] RReq_size,
  output logic              RReq_valid,
  input  logic              RReq_ready,
  input  logic [DATA_W-1:0] R_data,
  input  logic              R_valid,
  output logic              R_ready
);

  if (WR_LEN < 1) begin : g_bad_wr_len
    $error("WR_LEN must be >= 1");
  end
  if (NUM_RD < 1) begin : g_bad_num_rd
    $error("NUM_RD must be >= 1");
  end

  localparam logic [ADDR_W-1:0] WR_LEN_A  = ADDR_W'(WR_LEN);
  localparam logic [ADDR_W-1:0] WR_LAST_A = ADDR_W'(WR_LEN - 1);
  localparam logic [ADDR_W-1:0] RD_LAST_A = ADDR_W'(NUM_RD - 1);
  localparam logic [ADDR_W-1:0] SIZE0_A   = ADDR_W'(RD_SIZE_INIT);
  localparam logic [ADDR_W-1:0] SSTEP_A   = ADDR_W'(RD_SIZE_STEP);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DINIT_D   = DATA_W'(DATA_INIT);
  localparam logic [DATA_W-1:0] DSTEP_D   = DATA_W'(DATA_STEP);

  state_e            state_q, state_d;
  logic              wreq_valid_q, wreq_valid_d;
  logic [ADDR_W-1:0] wreq_size_q, wreq_size_d;
  logic              w_valid_q, w_valid_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic              rreq_valid_q, rreq_valid_d;
  logic [ADDR_W-1:0] rreq_addr_q, rreq_addr_d;
  logic [ADDR_W-1:0] rreq_size_q, rreq_size_d;
  logic              r_ready_q, r_ready_d;
  logic [ADDR_W-1:0] chunk_q, chunk_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              clear;
  logic              fire;

  assign fire = r_ready_q && R_valid;

  always_comb begin
    state_d      = state_q;
    wreq_valid_d = wreq_valid_q;
    wreq_size_d  = wreq_size_q;
    w_valid_d    = w_valid_q;
    w_data_d     = w_data_q;
    word_d       = word_q;
    rreq_valid_d = rreq_valid_q;
    rreq_addr_d  = rreq_addr_q;
    rreq_size_d  = rreq_size_q;
    r_ready_d    = r_ready_q;
    chunk_d      = chunk_q;
    rd_cnt_d     = rd_cnt_q;
    rd_addr_d    = rd_addr_q;
    clear        = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clear        = 1'b1;
          state_d      = S_WREQ;
          wreq_valid_d = 1'b1;
          wreq_size_d  = WR_LEN_A;
          word_d       = '0;
          chunk_d      = '0;
          rd_cnt_d     = '0;
          rd_addr_d    = '0;
        end
      end
      S_WREQ: begin
        if (WReq_ready) begin
          wreq_valid_d = 1'b0;
          w_valid_d    = 1'b1;
          w_data_d     = DINIT_D;
          word_d       = '0;
          state_d      = S_WDATA;
        end
      end
      S_WDATA: begin
        if (W_ready) begin
          if (word_q == WR_LAST_A) begin
            w_valid_d    = 1'b0;
            state_d      = S_RREQ;
            rreq_valid_d = 1'b1;
            rreq_addr_d  = '0;
            rreq_size_d  = SIZE0_A;
          end else begin
            word_d   = word_q + ONE_A;
            w_data_d = w_data_q + DSTEP_D;
          end
        end
      end
      S_RREQ: begin
        if (RReq_ready) begin
          rreq_valid_d = 1'b0;
          r_ready_d    = 1'b1;
          rd_cnt_d     = '0;
          state_d      = S_RDATA;
        end
      end
      S_RDATA: begin
        if (fire) begin
          rd_addr_d = rd_addr_q + ONE_A;
          rd_cnt_d  = rd_cnt_q + ONE_A;
          if (rd_cnt_q == rreq_size_q - ONE_A) begin
            r_ready_d = 1'b0;
            if (chunk_q == RD_LAST_A) begin
              state_d = S_DONE;
            end else begin
              // Next chunk starts right after the last word read.
              chunk_d      = chunk_q + ONE_A;
              state_d      = S_RREQ;
              rreq_valid_d = 1'b1;
              rreq_addr_d  = rd_addr_q + ONE_A;
              rreq_size_d  = rreq_size_q + SSTEP_A;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      wreq_valid_q <= 1'b0;
      wreq_size_q  <= '0;
      w_valid_q    <= 1'b0;
      w_data_q     <= '0;
      word_q       <= '0;
      rreq_valid_q <= 1'b0;
      rreq_addr_q  <= '0;
      rreq_size_q  <= '0;
      r_ready_q    <= 1'b0;
      chunk_q      <= '0;
      rd_cnt_q     <= '0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      wreq_valid_q <= wreq_valid_d;
      wreq_size_q  <= wreq_size_d;
      w_valid_q    <= w_valid_d;
      w_data_q     <= w_data_d;
      word_q       <= word_d;
      rreq_valid_q <= rreq_valid_d;
      rreq_addr_q  <= rreq_addr_d;
      rreq_size_q  <= rreq_size_d;
      r_ready_q    <= r_ready_d;
      chunk_q      <= chunk_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  axi_rd_checker #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DATA_INIT (DATA_INIT),
    .DATA_STEP (DATA_STEP)
  ) u_chk (
    .CLK         (CLK),
    .RESET       (RESET),
    .clear_i     (clear),
    .fire_i      (fire),
    .check_en_i  (rd_addr_q < WR_LEN_A),
    .addr_i      (rd_addr_q),
    .r_data_i    (R_data),
    .error_o     (error),
    .err_count_o (err_count)
  );

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign WReq_addr  = '0;
  assign WReq_size  = wreq_size_q;
  assign WReq_valid = wreq_valid_q;
  assign W_data     = w_data_q;
  assign W_valid    = w_valid_q;
  assign RReq_addr  = rreq_addr_q;
  assign RReq_size  = rreq_size_q;
  assign RReq_valid = rreq_valid_q;
  assign R_ready    = r_ready_q;

endmodule

// File: tb/tb_axi_seq_master.sv
// Scoreboard bench for axi_seq_master: AXI-side responder plus channel monitor.
// Second instance with long reads exercises error-count saturation.
module tb_axi_seq_master;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [7:0]  err_count;
  logic [31:0] WReq_addr, WReq_size, W_data;
  logic [31:0] RReq_addr, RReq_size;
  logic        WReq_valid, W_valid, RReq_valid, R_ready;
  logic        WReq_ready = 1'b0, W_ready = 1'b0;
  logic        RReq_ready = 1'b0, R_valid = 1'b0;
  logic [31:0] R_data = 32'd0;

  logic        s_start = 1'b0;
  logic        s_busy, s_done, s_error;
  logic [7:0]  s_err_count;
  logic [31:0] s_WReq_addr, s_WReq_size, s_W_data;
  logic [31:0] s_RReq_addr, s_RReq_size;
  logic        s_WReq_valid, s_W_valid, s_RReq_valid, s_R_ready;

  always #5 CLK = ~CLK;

  axi_seq_master u_dut (
    .CLK(CLK), .RESET(RESET), .start(start),
    .busy(busy), .done(done), .error(error), .err_count(err_count),
    .WReq_addr(WReq_addr), .WReq_size(WReq_size),
    .WReq_valid(WReq_valid), .WReq_ready(WReq_ready),
    .W_data(W_data), .W_valid(W_valid), .W_ready(W_ready),
    .RReq_addr(RReq_addr), .RReq_size(RReq_size),
    .RReq_valid(RReq_valid), .RReq_ready(RReq_ready),
    .R_data(R_data), .R_valid(R_valid), .R_ready(R_ready)
  );

  axi_seq_master #(
    .WR_LEN(300), .RD_SIZE_INIT(300), .NUM_RD(1)
  ) u_sat (
    .CLK(CLK), .RESET(RESET), .start(s_start),
    .busy(s_busy), .done(s_done), .error(s_error),
    .err_count(s_err_count),
    .WReq_addr(s_WReq_addr), .WReq_size(s_WReq_size),
    .WReq_valid(s_WReq_valid), .WReq_ready(1'b1),
    .W_data(s_W_data), .W_valid(s_W_valid), .W_ready(1'b1),
    .RReq_addr(s_RReq_addr), .RReq_size(s_RReq_size),
    .RReq_valid(s_RReq_valid), .RReq_ready(1'b1),
    .R_data(32'h5555_5555), .R_valid(1'b1), .R_ready(s_R_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] wreqq[$];
  logic [63:0] rreqq[$];
  logic [31:0] wq[$];
  int          rdq[$];

  bit stall_en = 0;
  bit spur_en = 0;
  int corrupt_addr = -1;
  int w_cnt = 0;
  int r_pops = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: transfers are decided at the following posedge, so the
  // negedge view of valid && ready is exactly what will be accepted.
  bit          wreq_hold = 0, w_hold = 0, rreq_hold = 0;
  logic [31:0] wreq_hold_sz, w_hold_d;
  logic [63:0] rreq_hold_p;
  logic [63:0] e;

  always @(negedge CLK) begin
    if (RESET) begin
      wreqq.delete(); rreqq.delete(); wq.delete(); rdq.delete();
      wreq_hold = 0; w_hold = 0; rreq_hold = 0;
    end else begin
      if (wreq_hold) begin
        chk("wreq_hold_valid", 64'(WReq_valid), 1);
        chk("wreq_hold_size", 64'(WReq_size), 64'(wreq_hold_sz));
      end
      if (w_hold) begin
        chk("w_hold_valid", 64'(W_valid), 1);
        chk("w_hold_data", 64'(W_data), 64'(w_hold_d));
      end
      if (rreq_hold) begin
        chk("rreq_hold_valid", 64'(RReq_valid), 1);
        chk("rreq_hold_pay", {RReq_addr, RReq_size}, rreq_hold_p);
      end
      if (WReq_valid && WReq_ready) begin
        if (wreqq.size() == 0) chk("wreq_unexp", 64'(wreqq.size()), 1);
        else begin
          e = wreqq.pop_front();
          chk("wreq_pay", {WReq_addr, WReq_size}, e);
        end
      end
      if (W_valid && W_ready) begin
        w_cnt++;
        if (wq.size() == 0) chk("w_unexp", 64'(wq.size()), 1);
        else chk("w_data", 64'(W_data), 64'(wq.pop_front()));
      end
      if (RReq_valid && RReq_ready) begin
        if (rreqq.size() == 0) chk("rreq_unexp", 64'(rreqq.size()), 1);
        else begin
          e = rreqq.pop_front();
          chk("rreq_pay", {RReq_addr, RReq_size}, e);
        end
        for (int i = 0; i < int'(RReq_size); i++)
          rdq.push_back(int'(RReq_addr) + i);
      end
      if (R_valid && R_ready) begin
        if (rdq.size() == 0) chk("r_unexp", 64'(rdq.size()), 1);
        else begin
          void'(rdq.pop_front());
          r_pops++;
        end
      end
      if (spur_en && (W_valid || WReq_valid))
        chk("r_ready_low", 64'(R_ready), 0);
      wreq_hold    = WReq_valid && !WReq_ready;
      wreq_hold_sz = WReq_size;
      w_hold       = W_valid && !W_ready;
      w_hold_d     = W_data;
      rreq_hold    = RReq_valid && !RReq_ready;
      rreq_hold_p  = {RReq_addr, RReq_size};
    end
  end

  // Responder: models the AXI block's ready lines and R channel.
  bit drv_real = 0;
  int drv_last = 0;
  int drv_a;

  always begin
    @(posedge CLK);
    #1;
    WReq_ready = stall_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
    W_ready    = stall_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
    RReq_ready = stall_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
    if (RESET) begin
      R_valid  = 1'b0;
      drv_real = 0;
    end else if (!R_valid || !drv_real || r_pops != drv_last) begin
      if (rdq.size() > 0 &&
          (!stall_en || $urandom_range(0, 9) >= 3)) begin
        drv_a    = rdq[0];
        R_valid  = 1'b1;
        drv_real = 1;
        R_data   = (drv_a == corrupt_addr) ? 32'hFFFF : 32'(2 * drv_a);
      end else if (spur_en && rdq.size() == 0) begin
        R_valid  = 1'($urandom_range(0, 1));
        drv_real = 0;
        R_data   = 32'hDEAD_BEEF;
      end else begin
        R_valid  = 1'b0;
        drv_real = 0;
      end
    end
    drv_last = r_pops;
  end

  task automatic push_default;
    wreqq.push_back({32'd0, 32'd18});
    for (int i = 0; i < 18; i++) wq.push_back(32'(2 * i));
    rreqq.push_back({32'd0, 32'd3});
    rreqq.push_back({32'd3, 32'd6});
    rreqq.push_back({32'd9, 32'd9});
  endtask

  task automatic launch;
    int n;
    @(posedge CLK);
    #1 start = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!busy && n < 20);
    chk("start_ack", 64'(busy), 1);
    chk("err_cleared", 64'(error), 0);
    chk("cnt_cleared", 64'(err_count), 0);
    start = 1'b0;
  endtask

  task automatic run_seq(input logic exp_err, input logic [7:0] exp_cnt);
    int n;
    push_default();
    launch();
    n = 0;
    while (!done && n < 4000) begin
      @(negedge CLK);
      n++;
    end
    chk("done", 64'(done), 1);
    chk("busy_end", 64'(busy), 0);
    chk("error_end", 64'(error), 64'(exp_err));
    chk("errcnt_end", 64'(err_count), 64'(exp_cnt));
    chk("wq_empty", 64'(wq.size() + wreqq.size()), 0);
    chk("rq_empty", 64'(rreqq.size() + rdq.size()), 0);
  endtask

  initial begin
    int n;
    int base;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_wreq_valid", 64'(WReq_valid), 0);
    chk("rst_w_valid", 64'(W_valid), 0);
    chk("rst_rreq_valid", 64'(RReq_valid), 0);
    chk("rst_r_ready", 64'(R_ready), 0);
    chk("rst_status", {busy, done, error}, 0);
    chk("rst_errcnt", 64'(err_count), 0);
    chk("rst_payload", {W_data, WReq_size}, 0);
    chk("rst_rreq_pay", {RReq_addr, RReq_size}, 0);
    RESET = 1'b0;

    run_seq(1'b0, 8'd0);

    stall_en = 1;
    run_seq(1'b0, 8'd0);
    stall_en = 0;

    corrupt_addr = 5;
    run_seq(1'b1, 8'd1);
    corrupt_addr = -1;

    spur_en = 1;
    run_seq(1'b0, 8'd0);
    spur_en = 0;

    // Abort after word 7 of the write burst.
    base = w_cnt;
    push_default();
    launch();
    n = 0;
    while (w_cnt - base < 8 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_word7", 64'(w_cnt - base), 8);
    @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort_valids", {WReq_valid, W_valid, RReq_valid, R_ready}, 0);
    chk("abort_status", {busy, done}, 0);
    chk("abort_wdata", 64'(W_data), 0);
    RESET = 1'b0;
    run_seq(1'b0, 8'd0);

    @(posedge CLK);
    #1 s_start = 1'b1;
    @(posedge CLK);
    #1 s_start = 1'b0;
    n = 0;
    while (!s_done && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("sat_done", 64'(s_done), 1);
    chk("sat_error", 64'(s_error), 1);
    chk("sat_errcnt", 64'(s_err_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
